// File: rtl/buspirate_pkg.sv
// Shared constants and FSM encoding for the MCU parallel-bus bridge.
package buspirate_pkg;

  localparam int MC_DATA_WIDTH = 16;
  localparam int MC_ADD_WIDTH  = 6;
  localparam logic [MC_ADD_WIDTH-1:0] SCRATCH_ADD = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_LATCH,
    ST_RD_DRV,
    ST_WAIT_REL
  } state_t;

endpackage

// File: rtl/mc_sync.sv
// Multi-bit 2-FF synchronizer; resets to all-ones so active-low strobes read as idle.
module mc_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  assign dout = sync_reg;

endmodule

// File: rtl/mc_bus_bridge.sv
// MCU async memory bus to single-cycle register bus bridge, with a link-test
// scratch register at SCRATCH_ADD.
module mc_bus_bridge
  import buspirate_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_oe,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
  output logic [MC_DATA_WIDTH-1:0] mc_data_out,
  output logic                     mc_data_oe,
  output logic [MC_ADD_WIDTH-1:0]  reg_add,
  output logic [MC_DATA_WIDTH-1:0] reg_wdata,
  output logic                     reg_wr,
  output logic                     reg_rd,
  input  logic [MC_DATA_WIDTH-1:0] reg_rdata,
  output logic                     bus_err
);

  logic [2:0] s_strb;
  logic       s_ce, s_we, s_oe;

  mc_sync #(.WIDTH(3)) u_sync (
    .clock (clock),
    .reset (reset),
    .din   ({mc_ce, mc_we, mc_oe}),
    .dout  (s_strb)
  );

  assign s_ce = s_strb[2];
  assign s_we = s_strb[1];
  assign s_oe = s_strb[0];

  state_t state_reg, state_next;

  // Covers the synchronizer refill after reset: a CE still low from an
  // aborted access must land in WAIT_REL instead of starting a new one.
  logic [2:0] flush_reg;

  logic [MC_DATA_WIDTH-1:0] scratch_reg;
  logic [MC_DATA_WIDTH-1:0] mc_data_out_reg;
  logic [MC_DATA_WIDTH-1:0] reg_wdata_reg;
  logic [MC_ADD_WIDTH-1:0]  reg_add_reg;
  logic                     reg_wr_reg, reg_rd_reg, bus_err_reg;

  logic add_hit;
  logic load_add, load_wdata, wr_pulse, rd_pulse, err_pulse, scratch_we, data_load;

  assign add_hit = (mc_add == SCRATCH_ADD);

  always_ff @(posedge clock) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_add   = 1'b0;
    load_wdata = 1'b0;
    wr_pulse   = 1'b0;
    rd_pulse   = 1'b0;
    err_pulse  = 1'b0;
    scratch_we = 1'b0;
    data_load  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!s_ce) begin
          if (flush_reg != 3'b000) begin
            state_next = ST_WAIT_REL;
          end else if (!s_we && !s_oe) begin
            err_pulse  = 1'b1;
            state_next = ST_WAIT_REL;
          end else if (!s_we) begin
            load_add   = 1'b1;
            load_wdata = 1'b1;
            wr_pulse   = !add_hit;
            scratch_we = add_hit;
            state_next = ST_WR;
          end else if (!s_oe) begin
            load_add   = 1'b1;
            rd_pulse   = !add_hit;
            state_next = ST_RD_REQ;
          end
        end
      end
      ST_WR:       state_next = ST_WAIT_REL;
      ST_RD_REQ:   state_next = ST_RD_LATCH;
      ST_RD_LATCH: begin
        data_load  = 1'b1;
        state_next = ST_RD_DRV;
      end
      ST_RD_DRV:   if (s_ce || s_oe) state_next = ST_IDLE;
      ST_WAIT_REL: if (s_ce) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flush_reg       <= 3'b111;
      scratch_reg     <= '0;
      mc_data_out_reg <= '0;
      reg_wdata_reg   <= '0;
      reg_add_reg     <= '0;
      reg_wr_reg      <= 1'b0;
      reg_rd_reg      <= 1'b0;
      bus_err_reg     <= 1'b0;
    end else begin
      flush_reg   <= {1'b0, flush_reg[2:1]};
      reg_wr_reg  <= wr_pulse;
      reg_rd_reg  <= rd_pulse;
      bus_err_reg <= err_pulse;
      if (load_add)   reg_add_reg   <= mc_add;
      if (load_wdata) reg_wdata_reg <= mc_data_in;
      if (scratch_we) scratch_reg   <= mc_data_in;
      if (data_load) begin
        mc_data_out_reg <= (reg_add_reg == SCRATCH_ADD) ? scratch_reg : reg_rdata;
      end
    end
  end

  // Raw pins gate the driver so the bus is released without synchronizer lag.
  assign mc_data_oe  = (state_reg == ST_RD_DRV) && !mc_oe && !mc_ce;
  assign mc_data_out = mc_data_out_reg;
  assign reg_add     = reg_add_reg;
  assign reg_wdata   = reg_wdata_reg;
  assign reg_wr      = reg_wr_reg;
  assign reg_rd      = reg_rd_reg;
  assign bus_err     = bus_err_reg;

endmodule

// File: tb/tb_mc_bus_bridge.sv
// Directed bench for mc_bus_bridge: access-level timing model plus per-cycle compare.
module tb_mc_bus_bridge;

  localparam int BIG = 1 << 30;
  localparam logic [5:0] SCR = 6'h3F;

  logic        clock = 1'b0;
  logic        reset;
  logic        mc_ce, mc_oe, mc_we;
  logic [5:0]  mc_add;
  logic [15:0] mc_data_in;
  logic [15:0] mc_data_out;
  logic        mc_data_oe;
  logic [5:0]  reg_add;
  logic [15:0] reg_wdata;
  logic        reg_wr, reg_rd;
  logic [15:0] reg_rdata;
  logic        bus_err;

  mc_bus_bridge dut (
    .clock       (clock),
    .reset       (reset),
    .mc_ce       (mc_ce),
    .mc_oe       (mc_oe),
    .mc_we       (mc_we),
    .mc_add      (mc_add),
    .mc_data_in  (mc_data_in),
    .mc_data_out (mc_data_out),
    .mc_data_oe  (mc_data_oe),
    .reg_add     (reg_add),
    .reg_wdata   (reg_wdata),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rdata   (reg_rdata),
    .bus_err     (bus_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: strobe-relative event schedule derived from access timing.
  bit          exp_wr  [0:4095];
  bit          exp_rd  [0:4095];
  bit          exp_err [0:4095];
  logic [5:0]  exp_add [0:4095];
  logic [15:0] exp_wd  [0:4095];
  int          drv_start = BIG;
  int          drv_end   = BIG;
  logic [15:0] drv_data  = 16'h0;
  logic [15:0] scratch_m = 16'h0;
  bit          chk_en    = 1'b0;
  int          n_wr = 0, n_rd = 0, n_err = 0;

  // Register file stand-in: data valid only in the cycle after reg_rd.
  bit          rd_seen = 1'b0;
  logic [15:0] rd_value = 16'h0;
  always @(negedge clock) rd_seen = reg_rd;
  always @(posedge clock) begin
    #1;
    reg_rdata = rd_seen ? rd_value : 16'hDEAD;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      bit exp_oe;
      exp_oe = (cyc >= drv_start) && (cyc < drv_end) && !mc_oe && !mc_ce;
      chk("reg_wr", {31'b0, reg_wr}, {31'b0, exp_wr[cyc]});
      chk("reg_rd", {31'b0, reg_rd}, {31'b0, exp_rd[cyc]});
      chk("bus_err", {31'b0, bus_err}, {31'b0, exp_err[cyc]});
      chk("mc_data_oe", {31'b0, mc_data_oe}, {31'b0, exp_oe});
      if (exp_wr[cyc]) begin
        chk("wr_add", {26'b0, reg_add}, {26'b0, exp_add[cyc]});
        chk("wr_data", {16'b0, reg_wdata}, {16'b0, exp_wd[cyc]});
      end
      if (exp_rd[cyc]) chk("rd_add", {26'b0, reg_add}, {26'b0, exp_add[cyc]});
      if (exp_oe) chk("rd_data", {16'b0, mc_data_out}, {16'b0, drv_data});
      if (reg_wr === 1'b1) n_wr++;
      if (reg_rd === 1'b1) n_rd++;
      if (bus_err === 1'b1) n_err++;
    end
  end

  // kind: 0 write, 1 read, 2 all strobes low
  task automatic do_access(input int kind, input logic [5:0] a, input logic [15:0] d,
                           input logic [15:0] rv, input int hold, input bit rst_mid);
    int t0;
    @(posedge clock);
    #1;
    t0 = cyc;
    mc_add = a;
    mc_data_in = d;
    rd_value = rv;
    mc_ce = 1'b0;
    mc_we = (kind == 0 || kind == 2) ? 1'b0 : 1'b1;
    mc_oe = (kind == 1 || kind == 2) ? 1'b0 : 1'b1;
    if (kind == 0) begin
      if (a == SCR) scratch_m = d;
      else begin
        exp_wr[t0+3] = 1'b1;
        exp_add[t0+3] = a;
        exp_wd[t0+3] = d;
      end
    end else if (kind == 1) begin
      if (a != SCR) begin
        exp_rd[t0+3] = 1'b1;
        exp_add[t0+3] = a;
      end
      drv_data  = (a == SCR) ? scratch_m : rv;
      drv_start = t0 + 5;
      drv_end   = BIG;
    end else begin
      exp_err[t0+3] = 1'b1;
    end
    repeat (hold) @(posedge clock);
    #1;
    if (rst_mid) begin
      reset = 1'b1;
      drv_end = cyc + 1;
      scratch_m = 16'h0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      chk("rst_data_out", {16'b0, mc_data_out}, 32'h0);
    end
    mc_ce = 1'b1;
    mc_we = 1'b1;
    mc_oe = 1'b1;
    drv_start = BIG;
    $display("access kind=%0d add=%h wdata=%h rdata=%h hold=%0d rst=%0d out=%h",
             kind, a, d, rv, hold, rst_mid, mc_data_out);
    repeat (4) @(posedge clock);
  endtask

  initial begin
    reset = 1'b1;
    mc_ce = 1'b1;
    mc_oe = 1'b1;
    mc_we = 1'b1;
    mc_add = 6'h0;
    mc_data_in = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_data_out", {16'b0, mc_data_out}, 32'h0);
    chk("reset_reg_add", {26'b0, reg_add}, 32'h0);
    chk("reset_reg_wdata", {16'b0, reg_wdata}, 32'h0);
    chk("reset_oe", {31'b0, mc_data_oe}, 32'h0);

    do_access(1, 6'h3F, 16'h0000, 16'h1111, 6, 1'b0);
    chk("scratch_read0", {16'b0, mc_data_out}, 32'h0000);
    do_access(0, 6'h3F, 16'hAA55, 16'h0000, 5, 1'b0);
    do_access(1, 6'h3F, 16'h0000, 16'h2222, 6, 1'b0);
    chk("scratch_readback", {16'b0, mc_data_out}, 32'hAA55);
    do_access(0, 6'h05, 16'h1234, 16'h0000, 5, 1'b0);
    chk("wr_add_hold", {26'b0, reg_add}, 32'h05);
    chk("wr_data_hold", {16'b0, reg_wdata}, 32'h1234);
    do_access(1, 6'h05, 16'h0000, 16'hBEEF, 10, 1'b0);
    chk("reg_read", {16'b0, mc_data_out}, 32'hBEEF);
    do_access(2, 6'h05, 16'h9999, 16'h3333, 6, 1'b0);
    chk("err_no_load", {16'b0, mc_data_out}, 32'hBEEF);
    do_access(1, 6'h05, 16'h0000, 16'h5A5A, 7, 1'b1);
    do_access(1, 6'h05, 16'h0000, 16'h7777, 7, 1'b0);
    chk("fresh_read", {16'b0, mc_data_out}, 32'h7777);

    @(negedge clock);
    chk("count_wr", n_wr, 32'd1);
    chk("count_rd", n_rd, 32'd3);
    chk("count_err", n_err, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
